// File: rtl/count_seq_monitor.sv
// Legality monitor for a LOW..HIGH wrap-around counter stream: locks, counts laps and faults.
// Optional build macro COUNT_SEQ_MON_STALL_EN treats a repeated sample as a legal stall.
module count_seq_monitor #(
  parameter int WIDTH  = 8,
  parameter int LOW    = 18,
  parameter int HIGH   = 27,
  parameter int LOCK_N = 2,
  parameter int LAP_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             wrap_pulse,
  output logic [LAP_W-1:0] lap_count,
  output logic             err_sticky,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam logic [WIDTH:0] C_LOW    = (WIDTH+1)'(LOW);
  localparam logic [WIDTH:0] C_HIGH   = (WIDTH+1)'(HIGH);
  localparam logic [WIDTH:0] C_ONE    = (WIDTH+1)'(1);
  localparam logic [3:0]     C_LOCK_N = 4'(LOCK_N);

  state_t             r_state;
  logic [WIDTH-1:0]   r_prev;
  logic [3:0]         r_good;
  logic               r_locked;
  logic               r_wrap;
  logic [LAP_W-1:0]   r_lap;
  logic               r_sticky;
  logic [7:0]         r_err;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_prev_nxt;
  logic [3:0]         w_good_nxt;
  logic               w_wrap_nxt;
  logic [LAP_W-1:0]   w_lap_nxt;
  logic               w_sticky_nxt;
  logic [7:0]         w_err_nxt;
  logic [7:0]         w_err_inc;
  logic [3:0]         w_good_inc;

  logic [WIDTH:0]     w_cnt_x;
  logic [WIDTH:0]     w_prev_x;
  logic               w_in_range;
  logic               w_step;
  logic               w_wrap;
  logic               w_legal;
  logic               w_stall;

  // One extra bit keeps prev+1 from overflowing in the step comparison.
  assign w_cnt_x    = {1'b0, count_in};
  assign w_prev_x   = {1'b0, r_prev};
  assign w_in_range = (w_cnt_x >= C_LOW) && (w_cnt_x <= C_HIGH);
  assign w_step     = (w_prev_x < C_HIGH) && (w_cnt_x == (w_prev_x + C_ONE));
  assign w_wrap     = (w_prev_x == C_HIGH) && (w_cnt_x == C_LOW);
  assign w_legal    = w_in_range && (w_step || w_wrap);
  assign w_err_inc  = (r_err == 8'hFF) ? r_err : (r_err + 8'd1);
  assign w_good_inc = r_good + 4'd1;

`ifdef COUNT_SEQ_MON_STALL_EN
  assign w_stall = (r_state != ST_IDLE) && (count_in == r_prev);
`else
  assign w_stall = 1'b0;
`endif

  // Next-state and next-counter logic; clr_err wins over a simultaneous sample.
  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev;
    w_good_nxt   = r_good;
    w_wrap_nxt   = 1'b0;
    w_lap_nxt    = r_lap;
    w_sticky_nxt = r_sticky;
    w_err_nxt    = r_err;
    if (clr_err) begin
      w_state_nxt  = ST_IDLE;
      w_good_nxt   = 4'd0;
      w_sticky_nxt = 1'b0;
      w_err_nxt    = 8'd0;
    end else if (en && !w_stall) begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_range) begin
            w_prev_nxt  = count_in;
            w_good_nxt  = 4'd0;
            w_state_nxt = ST_ACQ;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_ACQ: begin
          if (w_legal) begin
            w_prev_nxt = count_in;
            w_good_nxt = w_good_inc;
            if (w_good_inc >= C_LOCK_N) begin
              w_state_nxt = ST_LOCKED;
            end else begin
              w_state_nxt = ST_ACQ;
            end
          end else if (w_in_range) begin
            w_prev_nxt = count_in;
            w_good_nxt = 4'd0;
          end else begin
            w_good_nxt  = 4'd0;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (w_legal) begin
            w_prev_nxt = count_in;
            if (w_wrap) begin
              w_wrap_nxt = 1'b1;
              w_lap_nxt  = r_lap + 1'b1;
            end else begin
              w_wrap_nxt = 1'b0;
            end
          end else begin
            w_state_nxt  = ST_FAULT;
            w_sticky_nxt = 1'b1;
            w_err_nxt    = w_err_inc;
            if (w_in_range) begin
              w_prev_nxt = count_in;
            end else begin
              w_prev_nxt = r_prev;
            end
          end
        end
        ST_FAULT: begin
          if (w_in_range) begin
            w_prev_nxt = count_in;
          end else begin
            w_prev_nxt = r_prev;
          end
          if (!w_legal) begin
            w_err_nxt = w_err_inc;
          end else begin
            w_err_nxt = r_err;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_prev   <= '0;
      r_good   <= 4'd0;
      r_locked <= 1'b0;
      r_wrap   <= 1'b0;
      r_lap    <= '0;
      r_sticky <= 1'b0;
      r_err    <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= w_prev_nxt;
      r_good   <= w_good_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
      r_wrap   <= w_wrap_nxt;
      r_lap    <= w_lap_nxt;
      r_sticky <= w_sticky_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign locked     = r_locked;
  assign wrap_pulse = r_wrap;
  assign lap_count  = r_lap;
  assign err_sticky = r_sticky;
  assign err_count  = r_err;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed self-checking bench for count_seq_monitor (default parameters).
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] count_in = 8'd0;
  logic       clr_err = 1'b0;
  logic       locked;
  logic       wrap_pulse;
  logic [7:0] lap_count;
  logic       err_sticky;
  logic [7:0] err_count;

  int errors = 0;
  int checks = 0;

  count_seq_monitor dut (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clr_err(clr_err),
    .locked(locked), .wrap_pulse(wrap_pulse), .lap_count(lap_count),
    .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [7:0] v);
    @(negedge clk);
    en = 1'b1;
    count_in = v;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  // Starting from prev=20 while locked: one full lap back to 20.
  task automatic lap_from_20();
    for (int v = 21; v <= 27; v++) step(8'(v));
    step(8'd18);
    step(8'd19);
    step(8'd20);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin $display("FAIL reset_locked: got %0b want 0", locked); errors++; end
    checks++; if (wrap_pulse !== 1'b0) begin $display("FAIL reset_wrap: got %0b want 0", wrap_pulse); errors++; end
    checks++; if (lap_count !== 8'd0) begin $display("FAIL reset_lap: got %0d want 0", lap_count); errors++; end
    checks++; if (err_sticky !== 1'b0) begin $display("FAIL reset_sticky: got %0b want 0", err_sticky); errors++; end
    checks++; if (err_count !== 8'd0) begin $display("FAIL reset_err: got %0d want 0", err_count); errors++; end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_lock();
    step(8'd18);
    checks++; if (locked !== 1'b0) begin $display("FAIL lock_after18: got %0b want 0", locked); errors++; end
    step(8'd19);
    checks++; if (locked !== 1'b0) begin $display("FAIL lock_after19: got %0b want 0", locked); errors++; end
    step(8'd20);
    checks++; if (locked !== 1'b1) begin $display("FAIL lock_after20: got %0b want 1", locked); errors++; end
    checks++; if (err_count !== 8'd0) begin $display("FAIL lock_err: got %0d want 0", err_count); errors++; end
  endtask

  task automatic test_wrap();
    for (int v = 21; v <= 26; v++) step(8'(v));
    step(8'd27);
    checks++; if (wrap_pulse !== 1'b0) begin $display("FAIL wrap_before: got %0b want 0", wrap_pulse); errors++; end
    checks++; if (lap_count !== 8'd0) begin $display("FAIL lap_before: got %0d want 0", lap_count); errors++; end
    step(8'd18);
    checks++; if (wrap_pulse !== 1'b1) begin $display("FAIL wrap_pulse: got %0b want 1", wrap_pulse); errors++; end
    checks++; if (lap_count !== 8'd1) begin $display("FAIL lap_one: got %0d want 1", lap_count); errors++; end
    step(8'd19);
    checks++; if (wrap_pulse !== 1'b0) begin $display("FAIL wrap_single: got %0b want 0", wrap_pulse); errors++; end
  endtask

  task automatic test_lap_rollover();
    for (int k = 0; k < 255; k++) begin
      for (int v = 20; v <= 27; v++) step(8'(v));
      step(8'd18);
      step(8'd19);
      if (k == 253) begin
        checks++; if (lap_count !== 8'd255) begin $display("FAIL lap_255: got %0d want 255", lap_count); errors++; end
      end
    end
    checks++; if (lap_count !== 8'd0) begin $display("FAIL lap_rollover: got %0d want 0", lap_count); errors++; end
    checks++; if (locked !== 1'b1) begin $display("FAIL lap_locked: got %0b want 1", locked); errors++; end
  endtask

  task automatic test_en_hold();
    @(negedge clk);
    count_in = 8'd5;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (locked !== 1'b1) begin $display("FAIL hold_locked: got %0b want 1", locked); errors++; end
    checks++; if (err_count !== 8'd0) begin $display("FAIL hold_err: got %0d want 0", err_count); errors++; end
  endtask

  task automatic test_fault();
    step(8'd20);
    checks++; if (locked !== 1'b1) begin $display("FAIL fault_pre_locked: got %0b want 1", locked); errors++; end
    step(8'd22);
    checks++; if (locked !== 1'b0) begin $display("FAIL fault_locked: got %0b want 0", locked); errors++; end
    checks++; if (err_sticky !== 1'b1) begin $display("FAIL fault_sticky: got %0b want 1", err_sticky); errors++; end
    checks++; if (err_count !== 8'd1) begin $display("FAIL fault_err1: got %0d want 1", err_count); errors++; end
    step(8'd25);
    checks++; if (err_count !== 8'd2) begin $display("FAIL fault_err2: got %0d want 2", err_count); errors++; end
    step(8'd26);
    checks++; if (err_count !== 8'd2) begin $display("FAIL fault_legal26: got %0d want 2", err_count); errors++; end
  endtask

  task automatic test_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    checks++; if (err_count !== 8'd0) begin $display("FAIL clr_err0: got %0d want 0", err_count); errors++; end
    step(8'd18); step(8'd19); step(8'd20);
    repeat (3) lap_from_20();
    checks++; if (lap_count !== 8'd3) begin $display("FAIL clr_lap3: got %0d want 3", lap_count); errors++; end
    step(8'd25);
    checks++; if (err_sticky !== 1'b1) begin $display("FAIL clr_pre_sticky: got %0b want 1", err_sticky); errors++; end
    @(negedge clk);
    clr_err = 1'b1; en = 1'b1; count_in = 8'd19;
    @(posedge clk);
    #1;
    clr_err = 1'b0; en = 1'b0;
    checks++; if (err_sticky !== 1'b0) begin $display("FAIL clr_sticky: got %0b want 0", err_sticky); errors++; end
    checks++; if (err_count !== 8'd0) begin $display("FAIL clr_count: got %0d want 0", err_count); errors++; end
    checks++; if (lap_count !== 8'd3) begin $display("FAIL clr_lap_kept: got %0d want 3", lap_count); errors++; end
    step(8'd20);
    step(8'd21);
    checks++; if (locked !== 1'b0) begin $display("FAIL clr_discard: got %0b want 0", locked); errors++; end
    step(8'd22);
    checks++; if (locked !== 1'b1) begin $display("FAIL clr_relock: got %0b want 1", locked); errors++; end
  endtask

  task automatic test_stall();
    for (int v = 23; v <= 27; v++) step(8'(v));
    step(8'd18); step(8'd19); step(8'd20); step(8'd21);
    step(8'd21);
`ifdef COUNT_SEQ_MON_STALL_EN
    checks++; if (locked !== 1'b1) begin $display("FAIL stall_locked: got %0b want 1", locked); errors++; end
    checks++; if (err_count !== 8'd0) begin $display("FAIL stall_err: got %0d want 0", err_count); errors++; end
    step(8'd22);
    checks++; if (locked !== 1'b1) begin $display("FAIL stall_after22: got %0b want 1", locked); errors++; end
    checks++; if (err_count !== 8'd0) begin $display("FAIL stall_err22: got %0d want 0", err_count); errors++; end
`else
    checks++; if (locked !== 1'b0) begin $display("FAIL repeat_locked: got %0b want 0", locked); errors++; end
    checks++; if (err_count !== 8'd1) begin $display("FAIL repeat_err: got %0d want 1", err_count); errors++; end
    step(8'd22);
    checks++; if (err_count !== 8'd1) begin $display("FAIL repeat_err22: got %0d want 1", err_count); errors++; end
    checks++; if (err_sticky !== 1'b1) begin $display("FAIL repeat_sticky: got %0b want 1", err_sticky); errors++; end
`endif
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step(8'd30);
    checks++; if (err_count !== 8'd0) begin $display("FAIL oor_err: got %0d want 0", err_count); errors++; end
    checks++; if (err_sticky !== 1'b0) begin $display("FAIL oor_sticky: got %0b want 0", err_sticky); errors++; end
    step(8'd18);
    step(8'd19);
    checks++; if (locked !== 1'b0) begin $display("FAIL oor_acq: got %0b want 0", locked); errors++; end
    step(8'd20);
    checks++; if (locked !== 1'b1) begin $display("FAIL oor_lock: got %0b want 1", locked); errors++; end
  endtask

  task automatic test_async_reset();
    repeat (4) lap_from_20();
    for (int v = 21; v <= 27; v++) step(8'(v));
    step(8'd18);
    checks++; if (lap_count !== 8'd5) begin $display("FAIL ar_lap5: got %0d want 5", lap_count); errors++; end
    checks++; if (wrap_pulse !== 1'b1) begin $display("FAIL ar_wrap: got %0b want 1", wrap_pulse); errors++; end
    #2 rst = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin $display("FAIL ar_locked: got %0b want 0", locked); errors++; end
    checks++; if (wrap_pulse !== 1'b0) begin $display("FAIL ar_wrap0: got %0b want 0", wrap_pulse); errors++; end
    checks++; if (lap_count !== 8'd0) begin $display("FAIL ar_lap0: got %0d want 0", lap_count); errors++; end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_err_saturate();
    step(8'd18); step(8'd19); step(8'd20);
    step(8'd30);
    checks++; if (err_count !== 8'd1) begin $display("FAIL sat_first: got %0d want 1", err_count); errors++; end
    for (int i = 0; i < 259; i++) step(8'd30);
    checks++; if (err_count !== 8'd255) begin $display("FAIL sat_hold: got %0d want 255", err_count); errors++; end
    checks++; if (err_sticky !== 1'b1) begin $display("FAIL sat_sticky: got %0b want 1", err_sticky); errors++; end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_lap_rollover();
    test_en_hold();
    test_fault();
    test_clr();
    test_stall();
    test_out_of_range();
    test_async_reset();
    test_err_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
